// File: rtl/bram_arbiter.sv
// Round-robin arbiter giving two requesters turns on one single-port block RAM.
// One transaction in flight at a time, registered responses, per-transaction timeout.
module bram_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,

    input  logic             i_a_request,
    input  logic             i_a_rw,
    input  logic [31:0]      i_a_address,
    input  logic [WIDTH-1:0] i_a_wdata,
    output logic [WIDTH-1:0] o_a_rdata,
    output logic             o_a_ready,
    output logic             o_a_valid,

    input  logic             i_b_request,
    input  logic             i_b_rw,
    input  logic [31:0]      i_b_address,
    input  logic [WIDTH-1:0] i_b_wdata,
    output logic [WIDTH-1:0] o_b_rdata,
    output logic             o_b_ready,
    output logic             o_b_valid,

    output logic             o_bram_request,
    output logic             o_bram_rw,
    output logic [31:0]      o_bram_address,
    output logic [WIDTH-1:0] o_bram_wdata,
    input  logic [WIDTH-1:0] i_bram_rdata,
    input  logic             i_bram_ready,
    input  logic             i_bram_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESPOND
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t           r_state;
    logic             r_grant;
    logic             r_last_grant;
    logic [7:0]       r_count;

    logic [WIDTH-1:0] r_a_rdata;
    logic             r_a_valid;
    logic             r_a_ready;
    logic [WIDTH-1:0] r_b_rdata;
    logic             r_b_valid;
    logic             r_b_ready;

    logic             w_any_request;
    logic             w_pick;
    logic             w_timeout;

    assign w_any_request = i_a_request | i_b_request;
    assign w_timeout     = (r_count == LAST_COUNT);

    // On a tie the port that did not win last time gets the bus.
    always_comb begin
        w_pick = PORT_A;
        if (i_a_request && i_b_request) begin
            w_pick = ~r_last_grant;
        end else if (i_b_request) begin
            w_pick = PORT_B;
        end
    end

    // Dropping the request on ready keeps the RAM from seeing a second access.
    assign o_bram_request = (r_state == S_BUSY) && !i_bram_ready;
    assign o_bram_rw      = (r_grant == PORT_B) ? i_b_rw      : i_a_rw;
    assign o_bram_address = (r_grant == PORT_B) ? i_b_address : i_a_address;
    assign o_bram_wdata   = (r_grant == PORT_B) ? i_b_wdata   : i_a_wdata;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_grant      <= PORT_A;
            r_last_grant <= PORT_B;
            r_count      <= 8'd0;
            r_a_rdata    <= '0;
            r_a_valid    <= 1'b1;
            r_a_ready    <= 1'b0;
            r_b_rdata    <= '0;
            r_b_valid    <= 1'b1;
            r_b_ready    <= 1'b0;
        end else begin
            r_a_ready <= 1'b0;
            r_b_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_request) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_count      <= 8'd0;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (i_bram_ready) begin
                        if (r_grant == PORT_B) begin
                            r_b_rdata <= i_bram_rdata;
                            r_b_valid <= i_bram_valid;
                            r_b_ready <= 1'b1;
                        end else begin
                            r_a_rdata <= i_bram_rdata;
                            r_a_valid <= i_bram_valid;
                            r_a_ready <= 1'b1;
                        end
                        r_state <= S_RESPOND;
                    end else if (w_timeout) begin
                        // Abort: flag failure, keep the previous read data.
                        if (r_grant == PORT_B) begin
                            r_b_valid <= 1'b0;
                            r_b_ready <= 1'b1;
                        end else begin
                            r_a_valid <= 1'b0;
                            r_a_ready <= 1'b1;
                        end
                        r_state <= S_RESPOND;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                S_RESPOND: begin
                    // Requester still holds request this cycle; ignore it.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_a_valid = r_a_valid;
    assign o_a_ready = r_a_ready;
    assign o_b_rdata = r_b_rdata;
    assign o_b_valid = r_b_valid;
    assign o_b_ready = r_b_ready;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: a RAM model with optional stall,
// per-port expected-response queues and a negedge monitor.
module tb_bram_arbiter;

    localparam int W   = 32;
    localparam int TMO = 16;
    localparam logic [31:0] RANGE = 32'h0000_1000;
    localparam logic [31:0] BAD   = 32'hBAD0_BAD0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        valid;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_a_request, i_a_rw;
    logic [31:0]   i_a_address;
    logic [W-1:0]  i_a_wdata;
    logic [W-1:0]  o_a_rdata;
    logic          o_a_ready, o_a_valid;
    logic          i_b_request, i_b_rw;
    logic [31:0]   i_b_address;
    logic [W-1:0]  i_b_wdata;
    logic [W-1:0]  o_b_rdata;
    logic          o_b_ready, o_b_valid;
    logic          o_bram_request, o_bram_rw;
    logic [31:0]   o_bram_address;
    logic [W-1:0]  o_bram_wdata;
    logic [W-1:0]  ram_rdata;
    logic          ram_ready, ram_valid;
    logic          hang;

    always #5 clk = ~clk;

    bram_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_a_request    (i_a_request),
        .i_a_rw         (i_a_rw),
        .i_a_address    (i_a_address),
        .i_a_wdata      (i_a_wdata),
        .o_a_rdata      (o_a_rdata),
        .o_a_ready      (o_a_ready),
        .o_a_valid      (o_a_valid),
        .i_b_request    (i_b_request),
        .i_b_rw         (i_b_rw),
        .i_b_address    (i_b_address),
        .i_b_wdata      (i_b_wdata),
        .o_b_rdata      (o_b_rdata),
        .o_b_ready      (o_b_ready),
        .o_b_valid      (o_b_valid),
        .o_bram_request (o_bram_request),
        .o_bram_rw      (o_bram_rw),
        .o_bram_address (o_bram_address),
        .o_bram_wdata   (o_bram_wdata),
        .i_bram_rdata   (ram_rdata),
        .i_bram_ready   (ram_ready),
        .i_bram_valid   (ram_valid)
    );

    // RAM: one-cycle registered response, write-first, out of range above RANGE
    logic [31:0] ram_mem [0:1023];
    logic [31:0] shadow  [0:1023];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_ready <= 1'b0;
            ram_valid <= 1'b0;
            ram_rdata <= '0;
        end else begin
            ram_ready <= o_bram_request && !hang;
            if (o_bram_request) begin
                if (o_bram_address < RANGE) begin
                    ram_valid <= 1'b1;
                    if (o_bram_rw) begin
                        ram_mem[o_bram_address[11:2]] <= o_bram_wdata;
                        ram_rdata <= o_bram_wdata;
                    end else begin
                        ram_rdata <= ram_mem[o_bram_address[11:2]];
                    end
                end else begin
                    ram_valid <= 1'b0;
                    ram_rdata <= BAD;
                end
            end
        end
    end

    int cyc = 0;
    int bcnt = 0;
    int wcnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_bram_request) begin
            bcnt <= bcnt + 1;
            if (o_bram_rw) wcnt <= wcnt + 1;
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    resp_t qa[$];
    resp_t qb[$];
    int    order[$];
    resp_t snap_a, snap_b;
    logic [31:0] last_a, last_b;

    // Monitor: pops the expected response whenever a ready pulse appears
    always @(negedge clk) begin
        resp_t e;
        if (rst) begin
            snap_a = '{32'h0, 1'b1};
            snap_b = '{32'h0, 1'b1};
        end else begin
            if (o_a_ready || o_b_ready)
                chk("ready_exclusive", 32'(o_a_ready & o_b_ready), 32'd0);
            if (o_a_ready) begin
                order.push_back(0);
                if (qa.size() == 0) begin
                    chk("a_spurious_ready", 32'd1, 32'd0);
                end else begin
                    e = qa.pop_front();
                    chk("a_rdata", o_a_rdata, e.rdata);
                    chk("a_valid", 32'(o_a_valid), 32'(e.valid));
                    snap_a = e;
                end
                chk("b_rdata_hold", o_b_rdata, snap_b.rdata);
                chk("b_valid_hold", 32'(o_b_valid), 32'(snap_b.valid));
            end
            if (o_b_ready) begin
                order.push_back(1);
                if (qb.size() == 0) begin
                    chk("b_spurious_ready", 32'd1, 32'd0);
                end else begin
                    e = qb.pop_front();
                    chk("b_rdata", o_b_rdata, e.rdata);
                    chk("b_valid", 32'(o_b_valid), 32'(e.valid));
                    snap_b = e;
                end
                chk("a_rdata_hold", o_a_rdata, snap_a.rdata);
                chk("a_valid_hold", 32'(o_a_valid), 32'(snap_a.valid));
            end
        end
    end

    // Reference: each port is serial, so issue order equals response order
    task automatic issue(input bit port, input bit rw, input logic [31:0] addr,
                         input logic [31:0] wd, input bit tmo, output int lat);
        resp_t e;
        int start;
        bit got;
        if (tmo) begin
            e = '{(port ? last_b : last_a), 1'b0};
        end else if (addr < RANGE) begin
            if (rw) begin
                shadow[addr[11:2]] = wd;
                e = '{wd, 1'b1};
            end else begin
                e = '{shadow[addr[11:2]], 1'b1};
            end
        end else begin
            e = '{BAD, 1'b0};
        end
        if (port) begin
            last_b = e.rdata;
            qb.push_back(e);
        end else begin
            last_a = e.rdata;
            qa.push_back(e);
        end
        @(posedge clk); #1;
        if (port) begin
            i_b_request = 1'b1; i_b_rw = rw;
            i_b_address = addr; i_b_wdata = wd;
        end else begin
            i_a_request = 1'b1; i_a_rw = rw;
            i_a_address = addr; i_a_wdata = wd;
        end
        start = cyc;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (port ? o_b_ready : o_a_ready) begin
                got = 1'b1;
                break;
            end
        end
        lat = cyc - start;
        if (!got) chk(port ? "b_wait_ready" : "a_wait_ready", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (port) i_b_request = 1'b0;
        else i_a_request = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int lat, lat2, b0, w0, bc_a;
    bit got;
    logic [31:0] addr, wd;

    initial begin
        rst = 1'b1;
        hang = 1'b0;
        i_a_request = 0; i_a_rw = 0; i_a_address = 0; i_a_wdata = 0;
        i_b_request = 0; i_b_rw = 0; i_b_address = 0; i_b_wdata = 0;
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = 32'h0;
            shadow[i] = 32'h0;
        end
        ram_mem[4] = 32'hDEAD_BEEF;
        shadow[4] = 32'hDEAD_BEEF;
        last_a = 0;
        last_b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", 32'(o_a_ready), 32'd0);
        chk("rst_b_ready", 32'(o_b_ready), 32'd0);
        chk("rst_a_valid", 32'(o_a_valid), 32'd1);
        chk("rst_b_valid", 32'(o_b_valid), 32'd1);
        chk("rst_a_rdata", o_a_rdata, 32'd0);
        chk("rst_b_rdata", o_b_rdata, 32'd0);
        chk("rst_bram_req", 32'(o_bram_request), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Lone A read
        b0 = bcnt;
        issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, lat);
        chk("t1_latency", lat, 32'd3);
        chk("t1_bram_req_cycles", bcnt - b0, 32'd1);

        // Continuous contention: A reads, B writes
        order.delete();
        w0 = wcnt;
        fork
            begin
                int l;
                for (int i = 0; i < 4; i++)
                    issue(1'b0, 1'b0, 32'h10 + 32'(i * 4), 32'h0, 1'b0, l);
            end
            begin
                int l;
                for (int i = 0; i < 4; i++)
                    issue(1'b1, 1'b1, 32'h100 + 32'(i * 4), $urandom, 1'b0, l);
            end
        join
        chk("t2_count", order.size(), 32'd8);
        for (int i = 1; i < order.size(); i++)
            chk("t2_alternate", 32'(order[i] != order[i-1]), 32'd1);
        chk("t2_ram_writes", wcnt - w0, 32'd4);

        // Write through B, read back through A
        issue(1'b1, 1'b1, 32'h40, 32'h1234_5678, 1'b0, lat);
        issue(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, lat);

        // RAM stalls: A times out, then B is served
        order.delete();
        hang = 1'b1;
        b0 = bcnt;
        bc_a = -1;
        fork
            issue(1'b0, 1'b0, 32'h44, 32'h0, 1'b1, lat);
            begin
                @(posedge clk);
                issue(1'b1, 1'b0, 32'h104, 32'h0, 1'b0, lat2);
            end
            begin
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (o_a_ready) begin
                        bc_a = bcnt - b0;
                        break;
                    end
                end
                hang = 1'b0;
            end
        join
        chk("t4_bram_req_cycles", bc_a, 32'(TMO));
        chk("t4_count", order.size(), 32'd2);
        if (order.size() == 2) begin
            chk("t4_first_a", order[0], 32'd0);
            chk("t4_then_b", order[1], 32'd1);
        end

        // Out-of-range address
        issue(1'b1, 1'b0, 32'h3000, 32'h0, 1'b0, lat);

        // Reset during BUSY of an A read
        @(posedge clk); #1;
        i_a_request = 1'b1; i_a_rw = 1'b0; i_a_address = 32'h20;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_bram_request) begin
                got = 1'b1;
                break;
            end
        end
        chk("t6_busy_seen", 32'(got), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_drop", 32'(o_bram_request), 32'd0);
        chk("t6_rst_a_ready", 32'(o_a_ready), 32'd0);
        chk("t6_rst_a_valid", 32'(o_a_valid), 32'd1);
        chk("t6_rst_a_rdata", o_a_rdata, 32'd0);
        i_a_request = 1'b0;
        last_a = 0;
        last_b = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        order.delete();
        repeat (4) @(posedge clk);
        chk("t6_no_ready_after_abort", order.size(), 32'd0);
        fork
            begin
                int l;
                issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, l);
            end
            begin
                int l;
                issue(1'b1, 1'b0, 32'h108, 32'h0, 1'b0, l);
            end
        join
        chk("t6_count", order.size(), 32'd2);
        if (order.size() == 2) chk("t6_a_wins_tie", order[0], 32'd0);

        // Random concurrent traffic on disjoint regions
        fork
            begin
                int l;
                logic [31:0] ad;
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    ad = ($urandom_range(0, 7) == 0) ? 32'h2000
                       : {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                    issue(1'b0, 1'($urandom), ad, $urandom, 1'b0, l);
                end
            end
            begin
                int l;
                logic [31:0] ad;
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    ad = ($urandom_range(0, 7) == 0) ? 32'h2400
                       : {24'h1, 6'($urandom_range(0, 63)), 2'b00};
                    issue(1'b1, 1'($urandom), ad, $urandom, 1'b0, l);
                end
            end
        join
        repeat (4) @(posedge clk);
        chk("end_qa_empty", qa.size(), 32'd0);
        chk("end_qb_empty", qb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
